// File: rtl/packetizer_arbiter_vc.sv
// packetizer_arbiter_vc
// Round-robin arbiter that merges NUM_REQ requester streams (data, destination
// router, VC) into one registered output word for the packetizer.
// Optional burst lock: define PKTZ_ARB_BURST_LOCK_EN so that a winner keeps the
// grant for up to BURST_LEN consecutive transfers while it stays valid.
module packetizer_arbiter_vc #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 12,
    parameter int NUM_REQ          = 4,
    parameter int BURST_LEN        = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ*WIDTH_IN-1:0]          data_in,
    input  logic [NUM_REQ-1:0]                   valid_in,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]     dst_in,
    input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]  vc_in,
    output logic [NUM_REQ-1:0]                   ready_out,
    output logic [WIDTH_IN-1:0]                  data_out,
    output logic [ADDRESS_WIDTH-1:0]             dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]          vc_out,
    output logic [$clog2(NUM_REQ)-1:0]           src_out,
    output logic                                 valid_out,
    input  logic                                 ready_in
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int SW1   = SRC_W + 1;

    logic                        w_load_en;
    logic                        w_rr_found;
    logic                        w_any;
    logic                        w_xfer;
    logic [SRC_W-1:0]            r_ptr;
    logic [SRC_W-1:0]            w_ptr_nxt;
    logic [SRC_W-1:0]            w_start;
    logic [SRC_W-1:0]            w_rr_winner;
    logic [SRC_W-1:0]            w_winner;
    logic [SRC_W-1:0]            w_idx;
    logic [SRC_W:0]              w_sum;
    logic [NUM_REQ-1:0]          w_ready;
    logic [WIDTH_IN-1:0]         w_data;
    logic [ADDRESS_WIDTH-1:0]    w_dst;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc;

    logic                        r_valid;
    logic [WIDTH_IN-1:0]         r_data;
    logic [ADDRESS_WIDTH-1:0]    r_dst;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc;
    logic [SRC_W-1:0]            r_src;

    // Requester index plus one, wrapping NUM_REQ-1 back to 0.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        if (v == SRC_W'(NUM_REQ - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = v + SRC_W'(1);
        end
    endfunction

    // The output register may take a new word when empty or being drained.
    assign w_load_en = !r_valid | ready_in;
    assign w_xfer    = w_any & w_load_en & !rst;

    // Round-robin search: first valid requester at or after w_start, wrapping.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_start} + SW1'(k);
            if (w_sum >= SW1'(NUM_REQ)) begin
                w_sum = w_sum - SW1'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_rr_found && valid_in[w_idx]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_idx;
            end else begin
                w_rr_found  = w_rr_found;
            end
        end
    end

    // Steer the winner's fields to the output register and raise its ready.
    always_comb begin
        w_data  = '0;
        w_dst   = '0;
        w_vc    = '0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == SRC_W'(i)) begin
                w_data     = data_in[i*WIDTH_IN +: WIDTH_IN];
                w_dst      = dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_vc       = vc_in[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
                w_ready[i] = w_xfer;
            end else begin
                w_ready[i] = 1'b0;
            end
        end
    end

`ifdef PKTZ_ARB_BURST_LOCK_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SRC_W-1:0] r_owner;
    logic [SRC_W-1:0] w_owner_nxt;
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic [8:0]       w_count_inc;
    logic             w_owner_valid;
    logic             w_hold;

    // While locked the owner keeps the grant; if it drops, others are
    // arbitrated starting just after the owner.
    assign w_owner_valid = valid_in[r_owner];
    assign w_hold        = (r_state == ST_LOCKED) && w_owner_valid;
    assign w_start       = (r_state == ST_LOCKED) ? wrap_inc(r_owner) : r_ptr;
    assign w_winner      = w_hold ? r_owner : w_rr_winner;
    assign w_any         = w_hold | w_rr_found;
    assign w_count_inc   = {1'b0, r_count} + 9'd1;

    // Lock FSM next state, burst count and round-robin pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = wrap_inc(w_winner);
                    if (BURST_LEN > 1) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_winner;
                        w_count_nxt = 8'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_owner_valid) begin
                    if (w_xfer) begin
                        if (w_count_inc >= 9'(BURST_LEN)) begin
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = 8'd0;
                            w_ptr_nxt   = wrap_inc(r_owner);
                        end else begin
                            w_count_nxt = w_count_inc[7:0];
                        end
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 8'd0;
                    w_ptr_nxt   = wrap_inc(r_owner);
                    if (w_xfer) begin
                        w_ptr_nxt = wrap_inc(w_winner);
                        if (BURST_LEN > 1) begin
                            w_state_nxt = ST_LOCKED;
                            w_owner_nxt = w_winner;
                            w_count_nxt = 8'd1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = 8'd0;
            end
        endcase
    end

    // Lock FSM state, owner and burst count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_count <= w_count_nxt;
        end
    end
`else
    assign w_start  = r_ptr;
    assign w_winner = w_rr_winner;
    assign w_any    = w_rr_found;

    // Pointer moves past the winner on every transfer.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_xfer) begin
            w_ptr_nxt = wrap_inc(w_winner);
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end
`endif

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_dst   <= '0;
            r_vc    <= '0;
            r_src   <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_load_en) begin
                r_valid <= w_xfer;
                if (w_xfer) begin
                    r_data <= w_data;
                    r_dst  <= w_dst;
                    r_vc   <= w_vc;
                    r_src  <= w_winner;
                end
            end
        end
    end

    assign ready_out = w_ready;
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign dst_out   = r_dst;
    assign vc_out    = r_vc;
    assign src_out   = r_src;

endmodule
